// File: rtl/ddr3_traffic_gen_if.sv
// rtl/ddr3_traffic_gen_if.sv - app-side command/write/read bus between traffic generator and DDR3 controller
interface ddr3_traffic_gen_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 29
) ();
  logic [2:0]          app_cmd;
  logic                app_en;
  logic [ADDR_W-1:0]   app_addr;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                wr_data_rdy;
  logic                app_burst;
  logic                app_rd_data_valid;
  logic [DATA_W-1:0]   app_rd_data;
  logic                init_calib_complete;

  modport master (
    output app_cmd, app_en, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask, app_burst,
    input  app_rdy, wr_data_rdy, app_rd_data_valid, app_rd_data, init_calib_complete
  );

  modport slave (
    input  app_cmd, app_en, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask, app_burst,
    output app_rdy, wr_data_rdy, app_rd_data_valid, app_rd_data, init_calib_complete
  );
endinterface

// File: rtl/ddr3_traffic_gen.sv
// rtl/ddr3_traffic_gen.sv - write-then-read-back DDR3 pattern tester with pass/fail counters
module ddr3_traffic_gen #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 29,
  parameter int ADDR_STEP = 8,
  parameter int CNT_W     = 24,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  num_ok,
  output logic [CNT_W-1:0]  num_ng,
  output logic [ADDR_W-1:0] err_first_addr,
  output logic [2:0]        test_state,
  ddr3_traffic_gen_if.master app
);
  localparam int                LANES = DATA_W / 32;
  localparam int                BIT_W = $clog2(DATA_W);
  localparam int                TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [31:0]       SEED  = 32'hACE12468;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT_CAL = 3'd1, S_WRITE = 3'd2,
    S_READ_CMD = 3'd3, S_READ_WAIT = 3'd4, S_DONE = 3'd5
  } state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    nw_q;
  logic [2:0]          cmd_q;
  logic                en_q;
  logic                wren_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    w_idx;
  logic [31:0]         w_lfsr;
  logic [CNT_W-1:0]    rd_issued;
  logic [CNT_W-1:0]    r_idx;
  logic [31:0]         r_lfsr;
  logic [ADDR_W-1:0]   r_addr;
  logic [TO_W-1:0]     idle_cnt;
  logic                rd_beat;
  logic                rd_match;

  // Galois form of x^32+x^22+x^2+x+1, shifting right
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] gen_word(input logic [1:0] m, input logic [CNT_W-1:0] idx,
                                                 input logic [31:0] lf, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      case (m)
        2'd0:    w[32*k +: 32] = 32'(idx);
        2'd1:    w[32*k +: 32] = lf ^ 32'(k);
        2'd3:    w[32*k +: 32] = 32'(addr);
        default: ;
      endcase
    end
    if (m == 2'd2) w[BIT_W'(idx % DATA_W)] = 1'b1;
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign rd_beat  = app.app_rd_data_valid && (state == S_READ_CMD || state == S_READ_WAIT);
  assign rd_match = app.app_rd_data == gen_word(mode_q, r_idx, r_lfsr, r_addr);

  assign app.app_cmd      = cmd_q;
  assign app.app_en       = en_q;
  assign app.app_addr     = addr_q;
  assign app.app_wdf_data = wdata_q;
  assign app.app_wdf_wren = wren_q;
  assign app.app_wdf_end  = wren_q;
  assign app.app_wdf_mask = '0;
  assign app.app_burst    = 1'b0;
  assign test_state       = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;          mode_q <= '0;   base_q <= '0;  nw_q <= '0;
      cmd_q <= '0;              en_q <= 1'b0;   wren_q <= 1'b0;
      addr_q <= '0;             wdata_q <= '0;
      w_idx <= '0;              w_lfsr <= '0;   rd_issued <= '0;
      r_idx <= '0;              r_lfsr <= '0;   r_addr <= '0;  idle_cnt <= '0;
      busy <= 1'b0;             done <= 1'b0;   pass <= 1'b0;  timeout <= 1'b0;
      num_ok <= '0;             num_ng <= '0;   err_first_addr <= '0;
    end else begin
      // Read checker runs alongside command issue; only the first miss records its address
      if (rd_beat) begin
        if (rd_match) begin
          num_ok <= sat_inc(num_ok);
        end else begin
          num_ng <= sat_inc(num_ng);
          if (num_ng == '0) err_first_addr <= r_addr;
        end
        r_idx  <= r_idx + 1'b1;
        r_lfsr <= lfsr_step(r_lfsr);
        r_addr <= r_addr + STEP;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q <= mode;  base_q <= base_addr;  nw_q <= num_words;
            num_ok <= '0;    num_ng <= '0;         err_first_addr <= '0;
            done <= 1'b0;    pass <= 1'b0;         timeout <= 1'b0;
            busy <= 1'b1;
            state <= S_WAIT_CAL;
          end
        end
        S_WAIT_CAL: begin
          if (app.init_calib_complete) begin
            if (nw_q == '0) begin
              state <= S_DONE;  done <= 1'b1;  pass <= 1'b1;  busy <= 1'b0;
            end else begin
              state <= S_WRITE;
              en_q <= 1'b1;  wren_q <= 1'b1;  cmd_q <= 3'b000;
              addr_q <= base_q;
              w_idx <= '0;   w_lfsr <= SEED;
              wdata_q <= gen_word(mode_q, '0, SEED, base_q);
            end
          end
        end
        S_WRITE: begin
          if (app.app_rdy && app.wr_data_rdy) begin
            if (w_idx + 1'b1 == nw_q) begin
              state <= S_READ_CMD;
              wren_q <= 1'b0;  wdata_q <= '0;  cmd_q <= 3'b001;
              addr_q <= base_q;
              rd_issued <= '0;
              r_idx <= '0;     r_lfsr <= SEED;  r_addr <= base_q;
            end else begin
              w_idx   <= w_idx + 1'b1;
              w_lfsr  <= lfsr_step(w_lfsr);
              addr_q  <= addr_q + STEP;
              wdata_q <= gen_word(mode_q, w_idx + 1'b1, lfsr_step(w_lfsr), addr_q + STEP);
            end
          end
        end
        S_READ_CMD: begin
          if (app.app_rdy) begin
            rd_issued <= rd_issued + 1'b1;
            addr_q    <= addr_q + STEP;
            if (rd_issued + 1'b1 == nw_q) begin
              state <= S_READ_WAIT;  en_q <= 1'b0;  idle_cnt <= '0;
            end
          end
        end
        S_READ_WAIT: begin
          if (r_idx == nw_q) begin
            state <= S_DONE;  done <= 1'b1;  busy <= 1'b0;  pass <= (num_ng == '0);
          end else if (app.app_rd_data_valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TO_LAST) begin
            state <= S_DONE;  done <= 1'b1;  busy <= 1'b0;  timeout <= 1'b1;  pass <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// tb/tb_ddr3_traffic_gen.sv - table-driven bench with a behavioural MIG-style controller model
module tb_ddr3_traffic_gen;
  localparam int DW = 256;
  localparam int AW = 29;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_words = '0;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] num_ok, num_ng;
  logic [AW-1:0] err_first_addr;
  logic [2:0]    test_state;

  ddr3_traffic_gen_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ddr3_traffic_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .num_ok(num_ok), .num_ng(num_ng), .err_first_addr(err_first_addr),
    .test_state(test_state), .app(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode; int base; int nw; int pat; int restart; int corrupt; int drop;
    int e_ok; int e_ng; int e_err; int e_pass; int e_to;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } rd_t;

  vec_t          vecs[8];
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            rdy_pat = 0;
  int            corrupt_idx = -1;
  int            drop_idx = -1;
  int            rd_cnt = 0;
  int            proto_viol = 0;
  logic          hold_pend = 1'b0;
  logic [288:0]  hold_val;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wlog_addr[$];
  logic [DW-1:0] wlog_data[$];
  rd_t           rdq[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] exp_word(input int m, input int i, input logic [AW-1:0] a);
    logic [DW-1:0] w;
    logic [31:0]   l;
    w = '0;
    l = 32'hACE12468;
    case (m)
      0: for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = i;
      1: begin
        for (int s = 0; s < i; s++) l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
        for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = l ^ k;
      end
      2: w[i % DW] = 1'b1;
      default: for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = {3'b000, a};
    endcase
    return w;
  endfunction

  // Controller model: decides ready at the falling edge, so accept == what the DUT sees at the next rise
  always @(negedge clk) begin
    logic acc_w, acc_r;
    cyc++;
    if (rdy_pat == 0) begin
      bus.app_rdy = 1'b1;  bus.wr_data_rdy = 1'b1;
    end else begin
      bus.app_rdy = (cyc % 2) == 1;  bus.wr_data_rdy = (cyc % 10) > 2;
    end
    if (hold_pend && !rst && {bus.app_en, bus.app_cmd, bus.app_addr, bus.app_wdf_data} != hold_val) proto_viol++;
    if (bus.app_wdf_mask != '0 || bus.app_burst || bus.app_wdf_end != bus.app_wdf_wren ||
        (bus.app_wdf_wren && !(bus.app_en && bus.app_cmd == 3'b000))) proto_viol++;
    acc_w = bus.app_en && bus.app_cmd == 3'b000 && bus.app_rdy && bus.wr_data_rdy;
    acc_r = bus.app_en && bus.app_cmd == 3'b001 && bus.app_rdy;
    if (acc_w) begin
      mem[bus.app_addr] = bus.app_wdf_data;
      wlog_addr.push_back(bus.app_addr);
      wlog_data.push_back(bus.app_wdf_data);
    end
    if (acc_r) begin
      rd_t e;
      e.d = mem.exists(bus.app_addr) ? mem[bus.app_addr] : '0;
      if (rd_cnt == corrupt_idx) e.d[5] = ~e.d[5];
      e.due = cyc + 3;
      if (rd_cnt != drop_idx) rdq.push_back(e);
      rd_cnt++;
    end
    hold_pend = bus.app_en && !acc_w && !acc_r;
    hold_val  = {bus.app_en, bus.app_cmd, bus.app_addr, bus.app_wdf_data};
    if (rdq.size() > 0 && rdq[0].due <= cyc) begin
      bus.app_rd_data_valid = 1'b1;  bus.app_rd_data = rdq[0].d;  void'(rdq.pop_front());
    end else begin
      bus.app_rd_data_valid = 1'b0;
    end
  end

  task automatic setup_model(input int pat, input int corrupt, input int drop);
    rdy_pat = pat;  corrupt_idx = corrupt;  drop_idx = drop;
    rd_cnt = 0;  proto_viol = 0;
    wlog_addr.delete();  wlog_data.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, test_state, 0);   chk({tag, "_en"}, bus.app_en, 0);
    chk({tag, "_wren"}, bus.app_wdf_wren, 0); chk({tag, "_wend"}, bus.app_wdf_end, 0);
    chk({tag, "_cmd"}, bus.app_cmd, 0);    chk({tag, "_addr"}, bus.app_addr, 0);
    chk({tag, "_wdata"}, bus.app_wdf_data, 0);
    chk({tag, "_busy"}, busy, 0);          chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);          chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_ok"}, num_ok, 0);          chk({tag, "_ng"}, num_ng, 0);
    chk({tag, "_err"}, err_first_addr, 0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int            guard;
    logic [AW-1:0] ea;
    string         p;
    p = $sformatf("v%0d", id);
    setup_model(v.pat, v.corrupt, v.drop ? v.nw - 1 : -1);
    mode = 2'(v.mode);  base_addr = AW'(v.base);  num_words = CW'(v.nw);
    pulse_start();
    chk({p, "_busy_run"}, busy, 1);
    chk({p, "_state_cal"}, test_state, 1);
    // Inputs after start must not matter
    mode = ~mode;  num_words = 9;  base_addr = 'h55;
    guard = 0;
    while (!done && guard < 20000) begin
      start = (v.restart != 0 && guard == 5);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    chk({p, "_done_wait"}, guard < 20000, 1);
    chk({p, "_pass"}, pass, v.e_pass);     chk({p, "_timeout"}, timeout, v.e_to);
    chk({p, "_ok"}, num_ok, v.e_ok);       chk({p, "_ng"}, num_ng, v.e_ng);
    chk({p, "_err"}, err_first_addr, v.e_err);
    chk({p, "_busy_end"}, busy, 0);        chk({p, "_state_done"}, test_state, 5);
    chk({p, "_nwrites"}, wlog_addr.size(), v.nw);
    chk({p, "_nreads"}, rd_cnt, v.nw);
    chk({p, "_protocol"}, proto_viol, 0);
    for (int j = 0; j < v.nw && j < wlog_addr.size(); j++) begin
      ea = AW'(v.base + 8 * j);
      chk($sformatf("%s_waddr%0d", p, j), wlog_addr[j], ea);
      chk($sformatf("%s_wdata%0d", p, j), wlog_data[j], exp_word(v.mode, j, ea));
    end
  endtask

  initial begin
    int guard;
    //          mode base          nw pat rs  cor drop ok ng err      pass to
    vecs[0] = '{0, 'h0,          4, 0,  0, -1, 0,  4, 0, 0,       1, 0};
    vecs[1] = '{1, 'h40,         5, 0,  0, -1, 0,  5, 0, 0,       1, 0};
    vecs[2] = '{2, 'h1000,       6, 1,  1, -1, 0,  6, 0, 0,       1, 0};
    vecs[3] = '{3, 'h200,        4, 0,  0, -1, 0,  4, 0, 0,       1, 0};
    vecs[4] = '{0, 'h100,        5, 0,  0,  2, 0,  4, 1, 'h110,   0, 0};
    vecs[5] = '{1, 'h1FFFFFF8,   3, 0,  0, -1, 0,  3, 0, 0,       1, 0};
    vecs[6] = '{3, 'h80,         4, 0,  0, -1, 1,  3, 0, 0,       0, 1};
    vecs[7] = '{1, 'h0,          0, 0,  0, -1, 0,  0, 0, 0,       1, 0};

    bus.app_rdy = 1'b0;  bus.wr_data_rdy = 1'b0;  bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data = '0;  bus.init_calib_complete = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;

    // Calibration gate: stays in WAIT_CAL with no strobes until calib completes
    setup_model(0, -1, -1);
    mode = 2'd0;  base_addr = '0;  num_words = 2;
    pulse_start();
    repeat (4) @(negedge clk);
    chk("cal_state", test_state, 1);
    chk("cal_en", bus.app_en, 0);
    chk("cal_busy", busy, 1);
    bus.init_calib_complete = 1'b1;
    guard = 0;
    while (!done && guard < 2000) begin @(negedge clk); guard++; end
    chk("cal_done_wait", guard < 2000, 1);
    chk("cal_ok", num_ok, 2);
    chk("cal_pass", pass, 1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset during READ_CMD: abort, ignore stale read returns, then an empty mode-1 run
    setup_model(1, -1, -1);
    mode = 2'd0;  base_addr = AW'('h300);  num_words = 8;
    pulse_start();
    guard = 0;
    while (test_state != 3'd3 && guard < 2000) begin @(negedge clk); guard++; end
    chk("rst_reach_rdcmd", guard < 2000, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("stale_ok", num_ok, 0);
    chk("stale_ng", num_ng, 0);
    chk("stale_state", test_state, 0);
    chk("stale_done", done, 0);
    run_vec(7, vecs[7]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ddr3_traffic_gen.md
DDR3_TRAFFIC_GEN -- requirements
Module: ddr3_traffic_gen

Interface
REQ-001 Parameter DATA_W, 256, app data width in bits; multiple of 32.
REQ-002 Parameter ADDR_W, 29, app address width.
REQ-003 Parameter ADDR_STEP, 8, address increment per word (BL8).
REQ-004 Parameter CNT_W, 24, width of num_ok/num_ng/num_words.
REQ-005 Parameter TIMEOUT, 4096, max idle clk cycles waiting for read data.
REQ-006 One clock; reset is asynchronous and active-high; all state in clk domain.
REQ-007 clk  in  1  controller user clock (clk_x1).
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 start  in  1  single-cycle run request, sampled only in IDLE.
REQ-010 mode  in  2  pattern: 0 increment, 1 LFSR, 2 walking-one, 3 address-as-data.
REQ-011 base_addr  in  ADDR_W  first word address.
REQ-012 num_words  in  CNT_W  words per run; latched with base_addr and mode at start.
REQ-013 init_calib_complete  in  1  controller calibration done.
REQ-014 app_rdy / wr_data_rdy  in  1 each  controller command / write-data ready.
REQ-015 app_cmd out 3, app_en out 1, app_addr out ADDR_W: command channel.
REQ-016 app_wdf_data out DATA_W, app_wdf_wren out 1, app_wdf_end out 1, app_wdf_mask out DATA_W/8: write channel.
REQ-017 app_burst  out  1  tied 0.
REQ-018 app_rd_data_valid in 1, app_rd_data in DATA_W: read return.
REQ-019 busy, done, pass, timeout  out  1 each  run status.
REQ-020 num_ok, num_ng out CNT_W; err_first_addr out ADDR_W; test_state out 3.

Function
REQ-021 States (test_state encoding): IDLE=0, WAIT_CAL=1, WRITE=2, READ_CMD=3, READ_WAIT=4, DONE=5.
REQ-022 IDLE --start--> WAIT_CAL; latch inputs; clear counters, done, pass, timeout, err_first_addr; start while not IDLE is ignored.
REQ-023 WAIT_CAL --init_calib_complete--> WRITE; num_words==0 -> DONE directly with pass=1.
REQ-024 WRITE: app_en=app_wdf_wren=app_wdf_end=1, app_cmd=3'b000, held until a cycle with app_rdy && wr_data_rdy; that cycle completes one word.
REQ-025 Command and data always accepted in the same cycle; no partial acceptance; mask always all zeros.
REQ-026 After num_words accepted writes -> READ_CMD; address restarts at latched base_addr.
REQ-027 READ_CMD: app_en=1, app_cmd=3'b001; each app_rdy cycle issues one read; after num_words issued -> READ_WAIT (reads returning during READ_CMD counted normally).
REQ-028 Address increments by ADDR_STEP per accepted command, wraps modulo 2^ADDR_W.
REQ-029 Read data in order; each app_rd_data_valid compared full-width against regenerated expected word; match -> num_ok+1, else num_ng+1; counters saturate at 2^CNT_W-1.
REQ-030 First mismatch latches its word address into err_first_addr; later mismatches do not update it.
REQ-031 READ_WAIT: when returned count == num_words -> DONE; TIMEOUT consecutive cycles without valid -> DONE with timeout=1.
REQ-032 DONE: done=1, pass=(num_ng==0 && !timeout) held until next start; busy=1 in all states except IDLE and DONE; start from DONE behaves as from IDLE.
REQ-033 Patterns, word index i (0-based): mode0 each 32-bit lane = i; mode2 bit (i mod DATA_W) set, rest 0; mode3 each lane = word address zero-extended.
REQ-034 mode1: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seed 32'hACE12468 at start, stepped once per word; lane k = lfsr XOR k.
REQ-035 Write and read generators are independent instances, each advancing only on its own accepted word / valid beat.
REQ-036 app_en/app_wdf_wren deasserted in IDLE, WAIT_CAL, READ_WAIT, DONE.

Reset
REQ-037 rst asserted, any state: state IDLE, all strobes 0, app_cmd 0, app_addr 0, data 0, counters 0, busy/done/pass/timeout 0, err_first_addr 0.
REQ-038 Reset mid-run aborts immediately; outstanding controller reads returning after release are ignored in IDLE.

Verification
REQ-039 mode0, base 0, num_words 4, ideal model -> 4 writes at addr 0,8,16,24, lanes 0..3, done, pass=1, num_ok=4.
REQ-040 app_rdy toggling, wr_data_rdy low 3 cycles -> strobes held stable, no word lost or duplicated.
REQ-041 Model corrupts bit 5 of 3rd read word, base 0x100 -> num_ng=1, num_ok=N-1, err_first_addr=0x110, pass=0.
REQ-042 base = 2^ADDR_W-8, num_words 3 -> addresses wrap to 0, 8; pass=1.
REQ-043 Model drops last read -> timeout=1 after TIMEOUT cycles, done=1, pass=0.
REQ-044 rst asserted in READ_CMD, then start mode1 num_words 0 -> all outputs at reset values, then done=1, pass=1 with no commands.
